tj_leak_rx: RTL and testbench
=============================

// Module: tj_leak_rx
// PURPOSE
// - Receive end of the AES trust-bench covert leakage channel. Frames a serial leak bit stream
//   (preamble + KEY_W payload bits + even-parity bit) and rebuilds the 128-bit round key.
// - Sits in the verification/attack harness next to the AES core. Recovered keys go out over a
//   valid/ready handshake to the scoreboard.
// PARAMETERS
// - KEY_W     128    payload width in bits
// - PRE_W     8      preamble width in bits
// - PREAMBLE  8'hAA  sync pattern (10101010), MSB received first
// - TIMEOUT   255    idle cycles with no leak_valid in RECV/PAR before abort; 8-bit counter
// PORTS
// - clk        in   1      rising-edge clock
// - rst        in   1      reset, synchronous, active-high
// - leak_valid in   1      leak_bit qualifier; one bit per asserted cycle
// - leak_bit   in   1      serial channel bit, MSB-first
// - key_ready  in   1      downstream accepts key_out
// - key_out    out  KEY_W  recovered key; stable while key_valid=1
// - key_valid  out  1      key_out valid; held until key_ready
// - locked     out  1      1 while in RECV or PAR
// - par_err    out  1      1-cycle pulse on parity mismatch
// - tmo        out  1      1-cycle pulse on idle timeout abort
// - overrun    out  1      sticky; set when a valid bit is dropped in OUT; cleared only by rst
// - err_cnt    out  8      saturating count of par_err + tmo events
// BEHAVIOUR
// - Reset (rst=1 at posedge): state=HUNT, shift reg=0, bit cnt=0, idle cnt=0.
//   All outputs 0, including key_out, err_cnt and overrun. Wins over every other event.
// - HUNT: on leak_valid, sr <= {sr[PRE_W-2:0],leak_bit}.
//   If the new sr value == PREAMBLE, go to RECV with cnt=0 and payload=0.
//   Preamble matching is sliding: overlapping prefixes are detected.
// - RECV: on leak_valid, payload <= {payload[KEY_W-2:0],leak_bit} and cnt++.
//   The valid bit with cnt==KEY_W-1 moves to PAR.
// - PAR: on leak_valid, compare leak_bit against ^payload.
//   - Equal: go to OUT; key_out <= payload and key_valid <= 1 in the same edge.
//     Latency is 1 clk after the parity bit is sampled.
//   - Unequal: par_err pulses, err_cnt++ (saturates at 255), go to HUNT with sr=0.
// - OUT: key_valid=1 and key_out held until key_valid&key_ready at a posedge, then HUNT with sr=0.
//   - Any leak_valid while in OUT, including the handshake cycle, drops the bit and sets overrun.
// - Idle timeout (RECV/PAR only):
//   - idle cnt resets on each leak_valid and counts otherwise.
//   - On reaching TIMEOUT: tmo pulses, err_cnt++, go to HUNT with sr=0, payload discarded.
//   - A leak_valid in the same cycle wins: the bit is consumed and there is no timeout.
// - par_err and tmo never assert in the same cycle. key_valid only deasserts via handshake or rst.
// - Reset mid-frame or mid-OUT: the frame is lost and key_valid drops on the next cycle.
// - locked = (state==RECV || state==PAR), registered with the state.
// STRUCTURE
// - Package tj_leak_pkg: state enum {HUNT,RECV,PAR,OUT} (2-bit), default KEY_W, PRE_W,
//   PREAMBLE and TIMEOUT constants.
// - Sub-module tj_preamble_det (PRE_W/PREAMBLE params):
//   - sliding shift register with clr input
//   - 1-cycle-combinational match output
// - Top: FSM, payload shifter, parity accumulator (running XOR updated per bit, not a
//   KEY_W-wide reduce), idle and error counters.
// TESTING
// - Clean frame: AA, then key 00112233_44556677_8899aabb_ccddeeff MSB-first, then parity=^key.
//   -> key_valid 1 clk after the parity bit, key_out matches, err_cnt=0.
// - Bad parity: same frame with parity inverted -> par_err 1 cycle, err_cnt=1, locked=0, key_valid=0.
// - Sliding preamble: stream 1,0,1,0,1,0,1,0,1,0 then frame.
//   -> lock after the 8th bit; the next 128 bits are payload and the key is correct.
// - Timeout: lock, send 40 bits, idle 255 cycles -> tmo pulse, err_cnt=1, state HUNT.
//   Also: idle 254 cycles then resume -> frame completes normally.
// - Backpressure: key_ready=0 for 20 clk with bits arriving.
//   -> key_out stable, overrun=1; after key_ready=1, the next frame is received correctly.
// - Reset mid-payload at bit 64 -> all outputs 0 next cycle; a subsequent full frame decodes correctly.

Source files
------------

// File: rtl/tj_leak_pkg.sv
// tj_leak_pkg: shared state encoding and default framing constants for the leak receiver
package tj_leak_pkg;
    typedef enum logic [1:0] {HUNT, RECV, PAR, OUT} state_t;
    localparam int KEY_W_DEF = 128;
    localparam int PRE_W_DEF = 8;
    localparam logic [PRE_W_DEF-1:0] PREAMBLE_DEF = 8'hAA;
    localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/tj_preamble_det.sv
// tj_preamble_det: sliding preamble matcher with combinational match on the incoming bit
module tj_preamble_det
    import tj_leak_pkg::*;
#(
    parameter int PRE_W = PRE_W_DEF,
    parameter logic [PRE_W-1:0] PREAMBLE = PREAMBLE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic match
);
    logic [PRE_W-1:0] sr;
    logic [PRE_W-1:0] sr_n;
    assign sr_n = {sr[PRE_W-2:0], din};
    assign match = en && (sr_n == PREAMBLE);
    always_ff @(posedge clk) begin
        if (rst || clr) sr <= '0;
        else if (en) sr <= sr_n;
    end
endmodule

// File: rtl/tj_leak_rx.sv
// tj_leak_rx: frames preamble + payload + even parity from a serial leak stream and emits the key
module tj_leak_rx
    import tj_leak_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF,
    parameter int PRE_W = PRE_W_DEF,
    parameter logic [PRE_W-1:0] PREAMBLE = PREAMBLE_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             leak_valid,
    input  logic             leak_bit,
    input  logic             key_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             locked,
    output logic             par_err,
    output logic             tmo,
    output logic             overrun,
    output logic [7:0]       err_cnt
);
    localparam int CW = $clog2(KEY_W);
    state_t state, state_n;
    logic [KEY_W-1:0] payload;
    logic [CW-1:0] cnt;
    logic [7:0] idle;
    logic par, match, framing, tmo_hit, perr_hit, par_ok;
    tj_preamble_det #(.PRE_W(PRE_W), .PREAMBLE(PREAMBLE)) u_det (
        .clk(clk),
        .rst(rst),
        .clr(state != HUNT),
        .en(leak_valid && state == HUNT),
        .din(leak_bit),
        .match(match)
    );
    always_comb begin
        framing = (state == RECV) || (state == PAR);
        tmo_hit = framing && !leak_valid && (idle == 8'(TIMEOUT - 1));
        perr_hit = (state == PAR) && leak_valid && (leak_bit != par);
        par_ok = (state == PAR) && leak_valid && (leak_bit == par);
        state_n = (tmo_hit || perr_hit) ? HUNT :
                  (state == HUNT && match) ? RECV :
                  (state == RECV && leak_valid && cnt == CW'(KEY_W - 1)) ? PAR :
                  par_ok ? OUT :
                  (state == OUT && key_ready) ? HUNT : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
            payload <= '0;
            cnt <= '0;
            idle <= '0;
            par <= 1'b0;
            key_out <= '0;
            key_valid <= 1'b0;
            locked <= 1'b0;
            par_err <= 1'b0;
            tmo <= 1'b0;
            overrun <= 1'b0;
            err_cnt <= '0;
        end else begin
            state <= state_n;
            locked <= (state_n == RECV) || (state_n == PAR);
            par_err <= perr_hit;
            tmo <= tmo_hit;
            if (perr_hit || tmo_hit) err_cnt <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
            if (state == OUT && leak_valid) overrun <= 1'b1;
            // HUNT keeps the frame registers zeroed so RECV always starts clean
            if (state == HUNT) begin
                payload <= '0;
                cnt <= '0;
                idle <= '0;
                par <= 1'b0;
            end else if (framing) begin
                idle <= leak_valid ? 8'd0 : idle + 8'd1;
            end
            if (state == RECV && leak_valid) begin
                payload <= {payload[KEY_W-2:0], leak_bit};
                par <= par ^ leak_bit;
                cnt <= cnt + CW'(1);
            end
            if (par_ok) begin
                key_out <= payload;
                key_valid <= 1'b1;
            end
            if (state == OUT && key_ready) key_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_tj_leak_rx.sv
// tb_tj_leak_rx: scoreboard bench for the leak receiver framing, parity, timeout and backpressure
module tb_tj_leak_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic leak_valid = 1'b0;
    logic leak_bit = 1'b0;
    logic key_ready = 1'b1;
    logic [127:0] key_out;
    logic key_valid, locked, par_err, tmo, overrun;
    logic [7:0] err_cnt;
    int checks = 0;
    int failures = 0;
    logic [127:0] exp_q[$];
    logic [127:0] k1 = 128'h00112233_44556677_8899aabb_ccddeeff;
    logic [127:0] k2 = 128'h8899aabb_ccddeeff_00112233_44556677;
    logic [127:0] k3 = 128'hdeadbeef_01234567_89abcdef_f0e1d2c3;
    logic [7:0] pre = 8'hAA;

    tj_leak_rx dut (
        .clk(clk),
        .rst(rst),
        .leak_valid(leak_valid),
        .leak_bit(leak_bit),
        .key_ready(key_ready),
        .key_out(key_out),
        .key_valid(key_valid),
        .locked(locked),
        .par_err(par_err),
        .tmo(tmo),
        .overrun(overrun),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic b);
        leak_valid = 1'b1;
        leak_bit = b;
        tick();
        leak_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [127:0] k, input logic bad);
        for (int i = 7; i >= 0; i--) send(pre[i]);
        chk("lock_after_pre", 128'(locked), 128'd1);
        for (int i = 127; i >= 0; i--) send(k[i]);
        if (!bad) exp_q.push_back(k);
        send((^k) ^ bad);
    endtask

    always @(negedge clk) begin
        if (!rst && key_valid && key_ready) begin
            if (exp_q.size() == 0) chk("unexpected_key", key_out, 128'hx);
            else chk("key_out", key_out, exp_q.pop_front());
        end
    end

    initial begin
        tick(2);
        chk("rst_key_valid", 128'(key_valid), 128'd0);
        chk("rst_key_out", key_out, 128'd0);
        chk("rst_err_cnt", 128'(err_cnt), 128'd0);
        chk("rst_locked", 128'(locked), 128'd0);
        chk("rst_overrun", 128'(overrun), 128'd0);
        rst = 1'b0;
        tick();
        // clean frame
        send_frame(k1, 1'b0);
        chk("clean_key_valid", 128'(key_valid), 128'd1);
        chk("clean_err_cnt", 128'(err_cnt), 128'd0);
        chk("clean_locked", 128'(locked), 128'd0);
        tick(2);
        chk("clean_released", 128'(key_valid), 128'd0);
        // bad parity
        send_frame(k1, 1'b1);
        chk("bad_par_err", 128'(par_err), 128'd1);
        chk("bad_err_cnt", 128'(err_cnt), 128'd1);
        chk("bad_locked", 128'(locked), 128'd0);
        chk("bad_key_valid", 128'(key_valid), 128'd0);
        tick();
        chk("bad_par_pulse", 128'(par_err), 128'd0);
        // sliding preamble: the 8th of 10 alternating bits locks, last two start the payload
        for (int i = 0; i < 7; i++) send(~i[0]);
        chk("slide_no_lock7", 128'(locked), 128'd0);
        send(1'b0);
        chk("slide_lock8", 128'(locked), 128'd1);
        send(1'b1);
        send(1'b0);
        for (int i = 125; i >= 0; i--) send(k2[i]);
        exp_q.push_back(k2);
        send(^k2);
        chk("slide_key_valid", 128'(key_valid), 128'd1);
        tick(2);
        // timeout after 255 idle cycles
        for (int i = 7; i >= 0; i--) send(pre[i]);
        for (int i = 127; i >= 88; i--) send(k1[i]);
        tick(254);
        chk("tmo_not_yet", 128'(tmo), 128'd0);
        chk("tmo_still_locked", 128'(locked), 128'd1);
        tick();
        chk("tmo_pulse", 128'(tmo), 128'd1);
        chk("tmo_err_cnt", 128'(err_cnt), 128'd2);
        chk("tmo_unlocked", 128'(locked), 128'd0);
        tick();
        chk("tmo_pulse_end", 128'(tmo), 128'd0);
        // 254 idle cycles then resume
        for (int i = 7; i >= 0; i--) send(pre[i]);
        for (int i = 127; i >= 88; i--) send(k1[i]);
        tick(254);
        chk("idle254_locked", 128'(locked), 128'd1);
        for (int i = 87; i >= 0; i--) send(k1[i]);
        exp_q.push_back(k1);
        send(^k1);
        chk("idle254_key_valid", 128'(key_valid), 128'd1);
        chk("idle254_err_cnt", 128'(err_cnt), 128'd2);
        tick(2);
        // backpressure with bits arriving
        key_ready = 1'b0;
        send_frame(k3, 1'b0);
        for (int i = 0; i < 20; i++) begin
            send(i[0]);
            chk("bp_key_stable", key_out, k3);
            chk("bp_key_valid", 128'(key_valid), 128'd1);
        end
        chk("bp_overrun", 128'(overrun), 128'd1);
        key_ready = 1'b1;
        tick(2);
        chk("bp_released", 128'(key_valid), 128'd0);
        send_frame(k1, 1'b0);
        tick(2);
        // reset mid-payload
        for (int i = 7; i >= 0; i--) send(pre[i]);
        for (int i = 127; i >= 64; i--) send(k2[i]);
        rst = 1'b1;
        tick();
        chk("mid_rst_locked", 128'(locked), 128'd0);
        chk("mid_rst_err_cnt", 128'(err_cnt), 128'd0);
        chk("mid_rst_overrun", 128'(overrun), 128'd0);
        chk("mid_rst_key_out", key_out, 128'd0);
        chk("mid_rst_key_valid", 128'(key_valid), 128'd0);
        rst = 1'b0;
        tick();
        send_frame(k2, 1'b0);
        chk("post_rst_key_valid", 128'(key_valid), 128'd1);
        tick(3);
        chk("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
